// File: rtl/addr_seq_unlock_if.sv
// Bus-side signals of the 93xx knock-unlock engine.
// Strobe semantics: acc_stb is a one-clock pulse per bus access; ba, br_w and
// sser are valid only while acc_stb is high. There is no back-pressure, so
// every strobed access is consumed in the cycle it is presented. rd_oe and
// rd_data are combinational responses to that same access.
interface addr_seq_unlock_if;
    logic        acc_stb;
    logic        sser;
    logic [13:0] ba;
    logic        br_w;
    logic        rd_oe;
    logic        rd_data;

    modport master (output acc_stb, sser, ba, br_w, input rd_oe, rd_data);
    modport slave  (input acc_stb, sser, ba, br_w, output rd_oe, rd_data);
endinterface

// File: rtl/addr_seq_unlock.sv
// Address-sequence ("knock") unlock engine. Qualified reads into the decode
// window must present the key nibbles in BA[7:4] in order; a full match
// unlocks the gated read path until a relock read or any window write.
// Optional feature macro: ADDR_SEQ_TIMEOUT_EN (idle timeout that discards a
// partially entered key).
module addr_seq_unlock #(
    parameter int          KEY_LEN     = 6,
    parameter logic [63:0] KEY         = 64'h0000_00A9_5A3E,
    parameter logic [3:0]  RELOCK_NIB  = 4'hF,
    parameter int          TIMEOUT_CYC = 1024,
    localparam int         IDX_W       = $clog2(KEY_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    addr_seq_unlock_if.slave  bus,
    output logic              unlocked,
    output logic              unlock_pls,
    output logic [IDX_W-1:0]  seq_idx
);

    typedef enum logic {
        LOCKED   = 1'b0,
        UNLOCKED = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_LEN - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_eff;
    logic             pls_q, pls_d;
    logic             win, qrd, qwr;
    logic [3:0]       nib;
    logic             nib_hit, nib_first, nib_relock;
    logic             timeout_hit;
    logic             unused_ba;

    // Only BA[13:12] and BA[7:4] take part in decode and matching.
    assign unused_ba = ^{bus.ba[11:8], bus.ba[3:0]};

    function automatic logic [3:0] key_nib(input logic [IDX_W-1:0] i);
        return KEY[4*int'(i) +: 4];
    endfunction

    assign win = bus.acc_stb & ~bus.sser & ~bus.ba[13] & bus.ba[12];
    assign qrd = win & bus.br_w;
    assign qwr = win & ~bus.br_w;
    assign nib = bus.ba[7:4];

`ifdef ADDR_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;

    // Idle counter: cleared by any qualified access, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (win) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC));
`else
    assign timeout_hit = 1'b0;
`endif

    // A timed-out partial key behaves as if no nibble had been matched, so an
    // access in that same cycle is judged from the start of the key.
    assign idx_eff    = (timeout_hit && state_q == LOCKED) ? '0 : idx_q;
    assign nib_hit    = (nib == key_nib(idx_eff));
    assign nib_first  = (nib == key_nib('0));
    assign nib_relock = (nib == RELOCK_NIB);

    // State, index and unlock-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOCKED;
            idx_q   <= '0;
            pls_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pls_q   <= pls_d;
        end
    end

    // Next-state logic: key matching while locked, relock detection while unlocked.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_eff;
        pls_d   = 1'b0;
        case (state_q)
            LOCKED: begin
                if (qrd) begin
                    if (nib_hit) begin
                        if (idx_eff == LAST_IDX) begin
                            state_d = UNLOCKED;
                            idx_d   = '0;
                            pls_d   = 1'b1;
                        end else begin
                            idx_d = idx_eff + IDX_W'(1);
                        end
                    end else begin
                        // A wrong nibble may itself be the start of a new attempt.
                        idx_d = nib_first ? IDX_W'(1) : '0;
                    end
                end else if (qwr) begin
                    idx_d = '0;
                end
            end
            UNLOCKED: begin
                idx_d = '0;
                if ((qrd && nib_relock) || qwr) begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = LOCKED;
                idx_d   = '0;
            end
        endcase
    end

    assign unlocked    = (state_q == UNLOCKED);
    assign unlock_pls  = pls_q;
    assign seq_idx     = idx_q;
    // Read data comes from the pre-edge state, so a relocking read still sees UNLOCKED.
    assign bus.rd_oe   = qrd;
    assign bus.rd_data = unlocked ^ nib_hit;

endmodule
